nibble_serial_adder: RTL and testbench
======================================

// Module: nibble_serial_adder
//
// PURPOSE
//   Multi-cycle WIDTH-bit adder. Operands are accepted over a valid/ready handshake.
//   Each RUN cycle one nibble is fed, LSB first, into a single skip4 instance (4-bit carry-skip slice).
//   The carry is held in a register between nibbles. The full sum is returned over a valid/ready handshake.
//   Sits directly upstream of skip4 as its operand/carry sequencer; area-saving alternative to a WIDTH-bit flat adder.
//
// PARAMETERS
//   WIDTH   16   operand/sum width; must be a multiple of 4 and >= 8 (elaboration error otherwise)
//   NIBBLES = WIDTH/4 is a localparam, not overridable
//
// PORTS
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous reset, active low
//   in_valid   in   1      operands a_i/b_i/cin_i valid
//   in_ready   out  1      block can accept operands (high only in IDLE)
//   a_i        in   WIDTH  operand A
//   b_i        in   WIDTH  operand B
//   cin_i      in   1      carry in
//   out_valid  out  1      sum_o/cout_o/ovf_o valid
//   out_ready  in   1      consumer accepts result
//   sum_o      out  WIDTH  A+B+Cin (mod 2^WIDTH)
//   cout_o     out  1      unsigned carry out of bit WIDTH-1
//   ovf_o      out  1      signed overflow
//   busy_o     out  1      high in RUN or DONE
//
// BEHAVIOUR
//   - Reset (async assert, sync to clk on release):
//     - State = IDLE; in_ready=1; out_valid=0; busy_o=0.
//     - sum_o=0, cout_o=0, ovf_o=0; carry register and nibble counter = 0.
//   - FSM states: IDLE, RUN, DONE.
//     - IDLE: in_valid&in_ready at edge T0 captures a_i, b_i, cin_i into operand registers.
//       - Carry register <= cin_i; counter <= 0; next state RUN.
//     - RUN: each edge registers one nibble.
//       - skip4 inputs: nibble[cnt] of A and B, plus the carry register.
//       - The skip4 4-bit sum goes into sum nibble[cnt]; the skip4 Cout goes into the carry register; cnt++.
//       - At the edge where cnt==NIBBLES-1: next state DONE, cout_o <= final Cout.
//         ovf_o <= (A[W-1]==B'[W-1]) & (S[W-1]!=A[W-1]), where B' is the effective B.
//     - DONE: out_valid=1. sum_o, cout_o and ovf_o are held stable while out_ready=0.
//       - out_valid&out_ready moves to IDLE at that edge.
//   - Latency: out_valid is first high exactly NIBBLES cycles after the accepting edge (4 cycles for WIDTH=16).
//   - Throughput: one op per NIBBLES+2 cycles minimum.
//     - No overlap: in_ready=0 in RUN and DONE, so in_valid is ignored there.
//     - In DONE, a same-cycle in_valid is not accepted; next acceptance is possible the cycle after return to IDLE.
//   - Outputs and state are registered; no combinational path from in_* to out_*.
//   - sum_o keeps its last value after the handshake until the next op overwrites nibbles.
//     It is valid only while out_valid=1.
//   - Carry skip through all nibbles (e.g. FFFF+0001) must ripple correctly across register boundaries.
//   - Reset mid-RUN or mid-DONE: transaction is dropped, all outputs return to reset values immediately, no out_valid.
//   - Operands changing on a_i/b_i after acceptance have no effect (captured copy used).
//
// CONFIGURATION
//   NIBBLE_SERIAL_SUB_EN
//     - Defined:
//       - Adds input port sub_i (1 bit), captured with the operands.
//       - When sub_i=1: effective B' = ~b_i and the initial carry = 1 (cin_i ignored), so sum_o = A-B.
//       - cout_o=1 means no borrow; ovf_o is computed using B'.
//     - Undefined:
//       - Port sub_i is absent; B' = b_i and the initial carry = cin_i (add only).
//
// TESTING (WIDTH=16)
//   1. Accept 0x1234+0x4321, cin=0
//      -> out_valid 4 cycles after accept; sum=0x5555, cout=0, ovf=0.
//   2. 0xFFFF+0x0001, cin=0
//      -> sum=0x0000, cout=1, ovf=0 (full carry-skip chain across all 4 nibbles).
//   3. 0x7FFF+0x0000, cin=1
//      -> sum=0x8000, cout=0, ovf=1; then 0x8000+0x8000 -> sum=0x0000, cout=1, ovf=1.
//   4. Hold out_ready=0 for 6 cycles in DONE with in_valid=1 and new operands
//      -> outputs stable, in_ready=0, new operands not taken; release -> IDLE, next op accepted afterwards.
//   5. Assert rst_n=0 two cycles into RUN
//      -> immediately in_ready=1, out_valid=0, sum_o=0, busy_o=0; next op 0x0001+0x0001 yields 0x0002.
//   6. (NIBBLE_SERIAL_SUB_EN) sub=1: 0x0005-0x0007
//      -> sum=0xFFFE, cout=0; 0x0007-0x0005 -> sum=0x0002, cout=1.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that feeds one nibble per cycle through a single skip4 slice.
// Optional subtract mode is enabled by defining NIBBLE_SERIAL_SUB_EN (adds port sub_i).

module skip4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);
   logic [3:0] p;
   logic [3:0] g;
   logic       c1, c2, c3, c4;

   always_comb begin
      p    = a ^ b;
      g    = a & b;
      c1   = g[0] | (p[0] & cin);
      c2   = g[1] | (p[1] & c1);
      c3   = g[2] | (p[2] & c2);
      c4   = g[3] | (p[3] & c3);
      sum  = p ^ {c3, c2, c1, cin};
      // When every bit propagates, the carry skips straight from cin.
      cout = (&p) ? cin : c4;
   end
endmodule

module nibble_serial_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
`ifdef NIBBLE_SERIAL_SUB_EN
   input  logic             sub_i,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o,
   output logic             ovf_o,
   output logic             busy_o
);
   localparam int NIBBLES = WIDTH / 4;
   localparam int CNT_W   = $clog2(NIBBLES);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

   if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_width_check
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 8");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q, sum_q;
   logic [CNT_W-1:0] cnt_q;
   logic             carry_q, cout_q, ovf_q;

   logic [WIDTH-1:0] b_eff;
   logic             carry_init;
   logic [3:0]       nib_a, nib_b, nib_sum;
   logic             nib_cout;

`ifdef NIBBLE_SERIAL_SUB_EN
   assign b_eff      = sub_i ? ~b_i : b_i;
   assign carry_init = sub_i ? 1'b1 : cin_i;
`else
   assign b_eff      = b_i;
   assign carry_init = cin_i;
`endif

   assign nib_a = a_q[{cnt_q, 2'b00} +: 4];
   assign nib_b = b_q[{cnt_q, 2'b00} +: 4];

   skip4 u_skip4 (
      .a    (nib_a),
      .b    (nib_b),
      .cin  (carry_q),
      .sum  (nib_sum),
      .cout (nib_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)       state_d = RUN;
         RUN:     if (cnt_q == LAST)  state_d = DONE;
         DONE:    if (out_ready)      state_d = IDLE;
         default:                     state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= a_i;
                  b_q     <= b_eff;
                  carry_q <= carry_init;
                  cnt_q   <= '0;
               end
            end
            RUN: begin
               sum_q[{cnt_q, 2'b00} +: 4] <= nib_sum;
               carry_q                    <= nib_cout;
               cnt_q                      <= cnt_q + 1'b1;
               // Top nibble: nib_sum[3] is the final sign bit of the result.
               if (cnt_q == LAST) begin
                  cout_q <= nib_cout;
                  ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) & (nib_sum[3] != a_q[WIDTH-1]);
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy_o    = (state_q != IDLE);
   assign sum_o     = sum_q;
   assign cout_o    = cout_q;
   assign ovf_o     = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed-vector bench for nibble_serial_adder (WIDTH=16); sub tests run when NIBBLE_SERIAL_SUB_EN is defined.

module tb_nibble_serial_adder;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a_i = '0;
   logic [W-1:0] b_i = '0;
   logic         cin_i = 1'b0;
   logic         sub_i = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] sum_o;
   logic         cout_o;
   logic         ovf_o;
   logic         busy_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   nibble_serial_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_i       (a_i),
      .b_i       (b_i),
      .cin_i     (cin_i),
`ifdef NIBBLE_SERIAL_SUB_EN
      .sub_i     (sub_i),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum_o     (sum_o),
      .cout_o    (cout_o),
      .ovf_o     (ovf_o),
      .busy_o    (busy_o)
   );

   // Accepts one op, scrambles inputs afterwards, waits for out_valid, returns results, then handshakes.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub,
                         output int lat, output logic [W-1:0] s, output logic co, output logic ov);
      a_i = a; b_i = b; cin_i = cin; sub_i = sub; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; a_i = ~a; b_i = ~b; cin_i = ~cin;
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (out_valid) begin lat = i; break; end
      end
      s = sum_o; co = cout_o; ov = ovf_o;
      if (lat != 0) begin
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy_o !== 1'b0)
         begin errors++; $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, want 1 0 0", in_ready, out_valid, busy_o); end
      checks++;
      if (sum_o !== 16'h0000 || cout_o !== 1'b0 || ovf_o !== 1'b0)
         begin errors++; $display("FAIL reset_data: sum=%h cout=%b ovf=%b, want 0000 0 0", sum_o, cout_o, ovf_o); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_add(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                           input logic [W-1:0] exp_s, input logic exp_c, input logic exp_v);
      int lat; logic [W-1:0] s; logic co, ov;
      run_op(a, b, cin, 1'b0, lat, s, co, ov);
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL %s_latency: got %0d want 4", name, lat); end
      checks++;
      if (s !== exp_s || co !== exp_c || ov !== exp_v)
         begin errors++; $display("FAIL %s_result: sum=%h cout=%b ovf=%b, want %h %b %b", name, s, co, ov, exp_s, exp_c, exp_v); end
      checks++;
      if (in_ready !== 1'b1 || busy_o !== 1'b0)
         begin errors++; $display("FAIL %s_idle: in_ready=%b busy=%b, want 1 0", name, in_ready, busy_o); end
   endtask

   task automatic test_backpressure;
      int lat; logic [W-1:0] s; logic co, ov;
      a_i = 16'h1111; b_i = 16'h2222; cin_i = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (busy_o !== 1'b1 || in_ready !== 1'b0)
         begin errors++; $display("FAIL bp_run: busy=%b in_ready=%b, want 1 0", busy_o, in_ready); end
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (out_valid) begin lat = i; break; end
      end
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL bp_latency: got %0d want 4", lat); end
      a_i = 16'hAAAA; b_i = 16'h5555; cin_i = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum_o !== 16'h3333 || cout_o !== 1'b0 || ovf_o !== 1'b0)
            begin errors++; $display("FAIL bp_hold%0d: ov=%b ir=%b sum=%h co=%b vf=%b, want 1 0 3333 0 0", i, out_valid, in_ready, sum_o, cout_o, ovf_o); end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy_o !== 1'b0)
         begin errors++; $display("FAIL bp_release: ir=%b ov=%b busy=%b, want 1 0 0", in_ready, out_valid, busy_o); end
      run_op(16'hAAAA, 16'h5555, 1'b0, 1'b0, lat, s, co, ov);
      checks++;
      if (lat !== 4 || s !== 16'hFFFF || co !== 1'b0 || ov !== 1'b0)
         begin errors++; $display("FAIL bp_next: lat=%0d sum=%h cout=%b ovf=%b, want 4 FFFF 0 0", lat, s, co, ov); end
   endtask

   task automatic test_reset_mid_run;
      int lat; logic [W-1:0] s; logic co, ov;
      a_i = 16'h1234; b_i = 16'h1111; cin_i = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum_o !== 16'h0000 || busy_o !== 1'b0)
         begin errors++; $display("FAIL midrun_reset: ir=%b ov=%b sum=%h busy=%b, want 1 0 0000 0", in_ready, out_valid, sum_o, busy_o); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(16'h0001, 16'h0001, 1'b0, 1'b0, lat, s, co, ov);
      checks++;
      if (lat !== 4 || s !== 16'h0002 || co !== 1'b0 || ov !== 1'b0)
         begin errors++; $display("FAIL midrun_next: lat=%0d sum=%h cout=%b ovf=%b, want 4 0002 0 0", lat, s, co, ov); end
   endtask

`ifdef NIBBLE_SERIAL_SUB_EN
   task automatic test_sub;
      int lat; logic [W-1:0] s; logic co, ov;
      run_op(16'h0005, 16'h0007, 1'b0, 1'b1, lat, s, co, ov);
      checks++;
      if (lat !== 4 || s !== 16'hFFFE || co !== 1'b0 || ov !== 1'b0)
         begin errors++; $display("FAIL sub_5m7: lat=%0d sum=%h cout=%b ovf=%b, want 4 FFFE 0 0", lat, s, co, ov); end
      run_op(16'h0007, 16'h0005, 1'b0, 1'b1, lat, s, co, ov);
      checks++;
      if (lat !== 4 || s !== 16'h0002 || co !== 1'b1 || ov !== 1'b0)
         begin errors++; $display("FAIL sub_7m5: lat=%0d sum=%h cout=%b ovf=%b, want 4 0002 1 0", lat, s, co, ov); end
      run_op(16'h8000, 16'h0001, 1'b0, 1'b1, lat, s, co, ov);
      checks++;
      if (lat !== 4 || s !== 16'h7FFF || co !== 1'b1 || ov !== 1'b1)
         begin errors++; $display("FAIL sub_ovf: lat=%0d sum=%h cout=%b ovf=%b, want 4 7FFF 1 1", lat, s, co, ov); end
   endtask
`endif

   initial begin
      test_reset();
      test_add("basic",   16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
      test_add("chain",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      test_add("pos_ovf", 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1);
      test_add("neg_ovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
      test_add("mixed",   16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0, 1'b0);
      test_backpressure();
      test_reset_mid_run();
`ifdef NIBBLE_SERIAL_SUB_EN
      test_sub();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
